// File: rtl/stopwatch_controller_if.sv
// Button and status bundle of the stopwatch controller.
// The master side owns the raw buttons and observes the status outputs.
// The slave side is the controller itself.
interface stopwatch_controller_if;
   logic       btn_start_stop;
   logic       btn_lap_clear;
   logic       sec_tick;
   logic       clear_cnt;
   logic       display_hold;
   logic       running;
   logic [1:0] state;

   modport master (
      output btn_start_stop,
      output btn_lap_clear,
      input  sec_tick,
      input  clear_cnt,
      input  display_hold,
      input  running,
      input  state
   );

   modport slave (
      input  btn_start_stop,
      input  btn_lap_clear,
      output sec_tick,
      output clear_cnt,
      output display_hold,
      output running,
      output state
   );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch control unit. Two raw push buttons are synchronized and
// debounced, and their press edges drive an IDLE/RUN/PAUSE/LAP state
// machine. A prescaler runs while the watch is running and emits one
// sec_tick per SECOND_REF cycles. clear_cnt tells the time counter to
// return to 00:00:00. All outputs come straight from flops.
module stopwatch_controller #(
   parameter int unsigned SECOND_REF = 250,
   parameter int unsigned DEBOUNCE   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   stopwatch_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   // Bit index of each button in the per-button vectors below.
   localparam int BTN_SS = 0;
   localparam int BTN_LC = 1;

   localparam logic [24:0] TICK_LAST = 25'(SECOND_REF - 1);
   localparam logic [16:0] DB_LIMIT  = 17'(DEBOUNCE);

   logic [1:0]  raw;
   logic [1:0]  sync1;
   logic [1:0]  sync2;
   logic [1:0]  level;
   logic [1:0]  level_d;
   logic [15:0] db_cnt [2];
   logic [1:0]  press;

   state_t      state_q;
   state_t      state_next;
   logic [24:0] prescaler;
   logic        sec_tick_q;
   logic        clear_cnt_q;
   logic        display_hold_q;
   logic        running_q;
   logic        advance;
   logic        clear_now;

   function automatic logic is_running(input state_t s);
      return (s == RUN) || (s == LAP);
   endfunction

   assign raw[BTN_SS] = bus.btn_start_stop;
   assign raw[BTN_LC] = bus.btn_lap_clear;

   // Two-flop synchronizers followed by a per-button debounce counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_d <= '0;
         // NOTE: these counters are reset even though they are an array; a
         // stale count surviving reset could let the first glitch through.
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != level[i]) begin
               // Accept the new level on the DEBOUNCE-th differing sample.
               if ({1'b0, db_cnt[i]} + 17'd1 == DB_LIMIT) begin
                  level[i]  <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 16'd1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // A press is the first cycle the debounced level reads high; releases
   // produce nothing. Built from flops only, so no input-to-output path.
   assign press = level & ~level_d;

   // Next-state decode; start/stop wins over lap/clear on a tie.
   always_comb begin
      // NOTE: defaulting first keeps every path assigned, so no latch.
      state_next = state_q;
      if (press[BTN_SS]) begin
         unique case (state_q)
            IDLE:  state_next = RUN;
            RUN:   state_next = PAUSE;
            LAP:   state_next = PAUSE;
            PAUSE: state_next = RUN;
         endcase
      end else if (press[BTN_LC]) begin
         unique case (state_q)
            IDLE:  state_next = IDLE;
            RUN:   state_next = LAP;
            LAP:   state_next = RUN;
            PAUSE: state_next = IDLE;
         endcase
      end
   end

   // The prescaler only counts edges that stay inside RUN/LAP. The edge
   // that enters RUN does not count, so the first tick lands SECOND_REF
   // cycles after RUN is visible. The edge that leaves for PAUSE does not
   // count either, so no tick can appear in PAUSE and the held phase
   // resumes exactly.
   assign advance   = is_running(state_q) && is_running(state_next);
   assign clear_now = (state_q == PAUSE) && (state_next == IDLE);

   // State register, prescaler and all registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         prescaler      <= '0;
         sec_tick_q     <= 1'b0;
         clear_cnt_q    <= 1'b0;
         display_hold_q <= 1'b0;
         running_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every flop here samples the
         // pre-edge values no matter how the statements are ordered.
         state_q        <= state_next;
         display_hold_q <= (state_next == LAP);
         running_q      <= is_running(state_next);
         sec_tick_q     <= 1'b0;
         clear_cnt_q    <= 1'b0;
         if (clear_now) begin
            prescaler   <= '0;
            clear_cnt_q <= 1'b1;
         end else if (advance) begin
            if (prescaler == TICK_LAST) begin
               prescaler  <= '0;
               sec_tick_q <= 1'b1;
            end else begin
               prescaler <= prescaler + 25'd1;
            end
         end
      end
   end

   assign bus.state        = state_q;
   assign bus.sec_tick     = sec_tick_q;
   assign bus.clear_cnt    = clear_cnt_q;
   assign bus.display_hold = display_hold_q;
   assign bus.running      = running_q;

   // Structural invariants of the outputs.
   a_tick_clear_exclusive: assert property (
      @(posedge clock) disable iff (!reset) !(sec_tick_q && clear_cnt_q));

   a_hold_matches_lap: assert property (
      @(posedge clock) disable iff (!reset) display_hold_q == (state_q == LAP));

   a_running_matches_state: assert property (
      @(posedge clock) disable iff (!reset) running_q == is_running(state_q));

   a_no_tick_outside_run: assert property (
      @(posedge clock) disable iff (!reset) sec_tick_q |-> is_running(state_q));

endmodule
